// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among four byte-stream requesters.
// A requester owns the transmitter for a whole message (up to its req_last byte).
// An owner that leaves its lane empty for 2^HOLD_W-1 LOAD cycles loses ownership.
// Optional feature: define UART_ARB_RR_EN for round-robin arbitration with a rotating
// pointer. Without it, arbitration is fixed priority with requester 0 highest.
module uart_tx_arbiter #(
    parameter int HOLD_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  ack,
    output logic [3:0]  abort,
    output logic [1:0]  owner,
    output logic        busy,
    input  logic        tx_ready,
    output logic        tx_load,
    output logic [7:0]  tx_data
);

    localparam int NUM_REQ = 4;
    localparam logic [HOLD_W-1:0] CNT_MAX = '1;

    // S_BLANK is the first WAIT cycle, where tx_ready may still be stale.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BLANK, S_WAIT} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 owner_q, owner_d;
    logic [HOLD_W-1:0]          cnt_q, cnt_d;
    logic                       last_q, last_d;
    logic                       tx_load_q, tx_load_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]         ack_q, ack_d;
    logic [NUM_REQ-1:0]         abort_q, abort_d;
    logic [NUM_REQ-1:0][7:0]    lane_data;
    logic [1:0]                 base;
    logic [1:0]                 win;
    logic [HOLD_W-1:0]          cnt_inc;

    assign lane_data = req_data;

`ifdef UART_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    // Rotating priority pointer; moves past the owner when it finishes or times out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`else
    assign base = 2'd0;
`endif

    // Winner search: first pending requester at or after base, wrapping 3 -> 0.
    always_comb begin
        win = base;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[base + 2'(k)]) win = base + 2'(k);
        end
    end

    // Saturating increment so the stall counter never wraps.
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    // Next-state and registered-output logic for the message FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_load_d = 1'b0;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        abort_d   = '0;
`ifdef UART_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((|req) && tx_ready) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req[owner_q] && tx_ready) begin
                    tx_load_d      = 1'b1;
                    tx_data_d      = lane_data[owner_q];
                    ack_d[owner_q] = 1'b1;
                    last_d         = req_last[owner_q];
                    state_d        = S_BLANK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        abort_d[owner_q] = 1'b1;
`ifdef UART_ARB_RR_EN
                        ptr_d = owner_q + 2'd1;
`endif
                        state_d = S_IDLE;
                    end
                end
            end
            S_BLANK: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_ready) begin
                    if (last_q) begin
`ifdef UART_ARB_RR_EN
                        ptr_d = owner_q + 2'd1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any load strobe in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 2'd0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tx_load_q <= 1'b0;
            tx_data_q <= 8'd0;
            ack_q     <= '0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tx_load_q <= tx_load_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            abort_q   <= abort_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign owner   = owner_q;
    assign tx_load = tx_load_q;
    assign tx_data = tx_data_q;
    assign ack     = ack_q;
    assign abort   = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random multi-byte messages from four
// requesters, a transmitter model, and a negedge monitor checking against a
// message-level model (per-requester byte queues plus an arbitration pointer).
module tb_uart_tx_arbiter;
    localparam int HOLD_W = 4;
    localparam int LONG   = 40;
    localparam int NMSG   = 8;
`ifdef UART_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_last, ack, abort;
    logic [31:0] req_data;
    logic [1:0]  owner;
    logic        busy, tx_ready, tx_load;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.HOLD_W(HOLD_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .abort(abort), .owner(owner), .busy(busy),
        .tx_ready(tx_ready), .tx_load(tx_load), .tx_data(tx_data)
    );

    typedef struct {
        bit         is_abort;
        logic [7:0] data;
        bit         last;
    } tok_t;

    tok_t exp_q [4][$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    bit   timed_out = 1'b0;
    int   lat_start = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for 1..6 cycles after every load.
    initial begin
        int frame;
        frame = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_load) begin
                tx_ready = 1'b0;
                frame = $urandom_range(1, 6);
            end else if (frame > 0) begin
                frame--;
                if (frame == 0) tx_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int         ptr_m = 0;
    bit         msg_active = 1'b0;
    logic [1:0] msg_owner = 2'd0;
    bit         prev_busy = 1'b0;
    logic [3:0] prev_req = 4'd0;
    logic       prev_rdy = 1'b0;
    bit         lat_done = 1'b0;
    tok_t       mt;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return 2'((p + k) % 4);
        end
        return 2'd0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outputs", {tx_load, tx_data, ack, abort, owner, busy} == '0,
                {tx_load, tx_data, ack, abort, owner, busy}, 0);
            ptr_m = 0;
            msg_active = 1'b0;
            prev_busy = 1'b0;
        end else begin
            chk("strobe_onehot", $countones({ack, abort}) <= 1, {ack, abort}, 0);
            chk("load_with_ack", tx_load == (ack != 4'd0), {tx_load, ack}, {ack != 4'd0, ack});
            if (tx_load) begin
                chk("ack_owner", ack == (4'd1 << owner), ack, 4'd1 << owner);
                chk("req_pending", prev_req[owner] == 1'b1, prev_req, 4'd1 << owner);
                if (lat_start >= 0 && !lat_done) begin
                    chk("first_latency", cyc - lat_start == 2, cyc - lat_start, 2);
                    lat_done = 1'b1;
                end
                if (msg_active) chk("ownership", owner == msg_owner, owner, msg_owner);
                if (exp_q[owner].size() == 0) begin
                    chk("unexpected_load", 1'b0, {owner, tx_data}, 0);
                end else begin
                    mt = exp_q[owner].pop_front();
                    chk("load_data", !mt.is_abort && mt.data == tx_data,
                        {mt.is_abort, tx_data}, {1'b0, mt.data});
                    if (mt.last) begin
                        msg_active = 1'b0;
                        if (RR) ptr_m = (int'(owner) + 1) % 4;
                    end else begin
                        msg_active = 1'b1;
                        msg_owner = owner;
                    end
                end
            end
            if (abort != 4'd0) begin
                chk("abort_owner", abort == (4'd1 << owner), abort, 4'd1 << owner);
                if (exp_q[owner].size() == 0) begin
                    chk("unexpected_abort", 1'b0, abort, 0);
                end else begin
                    mt = exp_q[owner].pop_front();
                    chk("abort_expected", mt.is_abort, 0, 1);
                end
                msg_active = 1'b0;
                if (RR) ptr_m = (int'(owner) + 1) % 4;
            end
            if (!prev_busy && busy)
                chk("grant_owner", owner == pick(prev_req, ptr_m), owner, pick(prev_req, ptr_m));
            if (!prev_busy && prev_req != 4'd0 && prev_rdy)
                chk("grant_taken", busy == 1'b1, busy, 1);
            prev_busy = busy;
        end
        prev_req = req;
        prev_rdy = tx_ready;
        if (done) begin
            int left;
            left = 0;
            for (int i = 0; i < 4; i++) left += exp_q[i].size();
            chk("queue_drained", left == 0, left, 0);
            chk("no_timeout", timed_out == 1'b0, timed_out, 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pb [4][4];
    int         pg [4][4];
    int         plen [4];
    int         pidx [4];
    int         st [4];
    int         cnt [4];
    int         msgs [4];
    bit         ab [4];

    // Plans a message and pushes the responses the arbiter owes for it.
    task automatic new_msg(input int i);
        plen[i] = $urandom_range(1, 4);
        for (int k = 0; k < 4; k++) begin
            pb[i][k] = 8'($urandom);
            pg[i][k] = ($urandom_range(0, 5) == 0) ? LONG : $urandom_range(0, 4);
        end
        if (i == 3 && msgs[i] == 0) begin
            plen[i] = 3;
            pg[i][0] = 1;
            pg[i][1] = LONG;
        end
        for (int k = 0; k < plen[i]; k++) begin
            exp_q[i].push_back('{1'b0, pb[i][k], k == plen[i] - 1});
            if (k < plen[i] - 1 && pg[i][k] == LONG) begin
                exp_q[i].push_back('{1'b1, 8'd0, 1'b0});
                break;
            end
        end
        pidx[i] = 0;
        msgs[i]++;
    endtask

    task automatic present(input int i);
        req[i] = 1'b1;
        req_data[8*i +: 8] = pb[i][pidx[i]];
        req_last[i] = (pidx[i] == plen[i] - 1);
    endtask

    initial begin
        int  w;
        bit  fin;
        reset = 1'b0;
        req = '0;
        req_last = '0;
        req_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-byte message from requester 2.
        exp_q[2].push_back('{1'b0, 8'hA5, 1'b1});
        req[2] = 1'b1;
        req_last[2] = 1'b1;
        req_data[23:16] = 8'hA5;
        lat_start = cyc;
        w = 0;
        while (!ack[2] && w < 20) begin @(posedge clk); #1; w++; end
        if (w >= 20) timed_out = 1'b1;
        req = '0;
        req_last = '0;
        w = 0;
        while (busy && w < 30) begin @(posedge clk); #1; w++; end
        if (w >= 30) timed_out = 1'b1;

        // Random multi-requester traffic.
        for (int i = 0; i < 4; i++) begin
            st[i] = 0; cnt[i] = 0; msgs[i] = 0; ab[i] = 1'b0; plen[i] = 1; pidx[i] = 0;
        end
        w = 0;
        fin = 1'b0;
        while (!fin && w < 20000) begin
            @(posedge clk);
            #1;
            w++;
            for (int i = 0; i < 4; i++) begin
                case (st[i])
                    0: begin
                        if (cnt[i] > 0) cnt[i]--;
                        else if (msgs[i] < NMSG) begin
                            new_msg(i);
                            present(i);
                            st[i] = 1;
                        end
                    end
                    1: begin
                        if (ack[i]) begin
                            if (pidx[i] == plen[i] - 1) begin
                                req[i] = 1'b0;
                                req_last[i] = 1'b0;
                                cnt[i] = $urandom_range(0, 8);
                                st[i] = 0;
                            end else begin
                                cnt[i] = pg[i][pidx[i]];
                                ab[i] = (cnt[i] == LONG);
                                pidx[i]++;
                                if (cnt[i] == 0) present(i);
                                else begin
                                    req[i] = 1'b0;
                                    st[i] = 2;
                                end
                            end
                        end
                    end
                    default: begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            if (ab[i]) begin
                                ab[i] = 1'b0;
                                cnt[i] = $urandom_range(0, 8);
                                st[i] = 0;
                            end else begin
                                present(i);
                                st[i] = 1;
                            end
                        end
                    end
                endcase
            end
            fin = 1'b1;
            for (int i = 0; i < 4; i++) if (msgs[i] < NMSG || st[i] != 0) fin = 1'b0;
        end
        if (!fin) timed_out = 1'b1;
        req = '0;
        req_last = '0;
        w = 0;
        while (busy && w < 100) begin @(posedge clk); #1; w++; end
        if (w >= 100) timed_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Two-byte message from requester 1, reset while waiting on the first frame.
        exp_q[1].push_back('{1'b0, 8'h3C, 1'b0});
        req[1] = 1'b1;
        req_last[1] = 1'b0;
        req_data[15:8] = 8'h3C;
        w = 0;
        while (!ack[1] && w < 40) begin @(posedge clk); #1; w++; end
        if (w >= 40) timed_out = 1'b1;
        req_data[15:8] = 8'hC3;
        req_last[1] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req = '0;
        req_last = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        done = 1'b1;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter in `uart_top` among four byte-stream requesters. Each requester is granted the transmitter for a whole message, not just one byte. The block sits between the requesters and the transmitter's load/ready handshake. It sequences one byte load per transmitter-ready, holds ownership until the requester's last byte, and releases the transmitter if the owner stalls too long.

## Interface
- `HOLD_W`, 10: width of the stall counter; owner timeout is 2^HOLD_W−1 cycles.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 4: requester i has a byte pending on its data lane.
- `req_data` in 32: byte for requester i on bits [8i+7:8i].
- `req_last` in 4: requester i's pending byte is the final byte of its message.
- `ack` out 4: one-cycle pulse; requester i's byte was loaded. The requester may update its data/last from the next cycle.
- `abort` out 4: one-cycle pulse; requester i lost ownership by timeout.
- `owner` out 2: index of the current owner; holds the last owner when idle.
- `busy` out 1: a message is in progress (state ≠ IDLE).
- `tx_ready` in 1: transmitter can accept a byte. It deasserts no later than the cycle after `tx_load` and reasserts when the frame is complete.
- `tx_load` out 1: one-cycle load strobe to the transmitter.
- `tx_data` out 8: byte to load; valid while `tx_load`=1.

## Operation
- **IDLE**
  - If any `req` bit is set and `tx_ready`=1, select a winner, register it into `owner`, clear the stall counter, and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - If `req[owner]`=1 and `tx_ready`=1: register `tx_load`=1, `tx_data`=owner's byte, `ack[owner]`=1, and `last_r`=`req_last[owner]`. Go to WAIT.
  - Otherwise increment the stall counter. When it reaches all-ones, pulse `abort[owner]`, advance the priority pointer, and go to IDLE.
- **WAIT**
  - The first cycle is blanking: `tx_ready` is ignored.
  - After blanking, wait for `tx_ready`=1.
  - On `tx_ready`=1 with `last_r`=1: advance the pointer to owner+1 (mod 4) and go to IDLE.
  - On `tx_ready`=1 with `last_r`=0: clear the stall counter and go to LOAD.
- **Ownership**
  - Non-owner requests are ignored until the state returns to IDLE.
  - A requester with `req`=1 and `req_last`=1 on its first byte sends a single-byte message.
- **Arbitration**
  - Round-robin when enabled (see Configuration): search starts at the pointer and wraps 3→0.
  - Fixed priority otherwise: index 0 is highest.
- **Stall counter**
  - HOLD_W bits; saturates at timeout and never wraps.
  - The counter runs only in LOAD.

## Timing
- **Reset values**
  - `tx_load`=0, `tx_data`=0, `ack`=0, `abort`=0, `owner`=0, `busy`=0.
  - State IDLE, pointer 0, counter 0, `last_r`=0.
- **Reset assertion**
  - Forces all of the above immediately, asynchronously, including mid-message.
  - A load strobe in flight is dropped. The requester receives no `ack`.
- **Latency**
  - `req` sampled in IDLE at cycle 0 → `busy`=1 and `owner` valid at cycle 1.
  - `tx_load`/`ack` at cycle 2 at the earliest.
- **Inter-byte gap**
  - `tx_ready` rising sampled at cycle n → next `tx_load` at n+2 at the earliest.
- **Strobes**
  - `tx_load`, `ack` and `abort` are registered single-cycle pulses.
  - `ack` is coincident with `tx_load`.
  - At most one `ack` or `abort` bit is set in any cycle.
- **Simultaneous events**
  - A new request arriving in the cycle the current owner finishes waits for IDLE. It is eligible on the following cycle.
  - `req[owner]` dropping in the same cycle as `tx_ready` in LOAD means no load; the counter increments.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin arbitration with a rotating pointer.
  - The pointer advances to owner+1 on message completion and on abort.
- `UART_ARB_RR_EN` undefined: fixed priority, index 0 highest.
  - No pointer register exists; all other behaviour is identical.

## Test plan
- Single requester: `req[2]`=1, `req_last[2]`=1, byte 0xA5, `tx_ready`=1 → `tx_load` with `tx_data`=0xA5 and `ack`=0100 two cycles later. Then `busy` falls after `tx_ready` recovers.
- Three-byte message from requester 1 (0x11, 0x22, 0x33 with last on 0x33) while `req[0]` is held → three loads, all to owner 1. Requester 0 is granted only after the third `tx_ready` rise.
- All four requesting with single-byte messages, `UART_ARB_RR_EN` defined → grant order 0,1,2,3,0. Without the macro → 0,0,0 while `req[0]` is held.
- Owner 3 drops `req` mid-message with `HOLD_W`=4 → `abort`=1000 after 15 LOAD cycles, then return to IDLE. Next grant goes to another pending requester.
- Assert `reset` low during WAIT of a two-byte message → all outputs read zero in the same cycle. After release, no `tx_load` until a fresh request.
